// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: executes 32-bit commands popped from a UART RX FIFO as single
// read/write transfers on a req/ack memory bus, and pushes status and read-data
// words back into the UART TX FIFO.
//
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   r_data, rx_empty, rd_uart   RX FIFO head word (show-ahead), empty flag, pop pulse
//   w_data, tx_full, wr_uart    TX FIFO push word, full flag, push pulse
//   mem_req/we/addr/wdata       bus request and its stable payload
//   mem_rdata, mem_ack          bus read data and completion
//   busy                        high whenever a command is in progress
//   err_cnt                     saturating count of error responses
//
// Header word: [31:24] opcode (01 write, 02 read), [23:0] address.
// Status word: {8'hAC, code, hdr[15:0]}; code 00 ok, 01 bad opcode, 02 bus timeout.
module uart_cmd_bridge #(
  parameter int unsigned AW     = 16,
  parameter int unsigned TO_CYC = 256,
  parameter int unsigned TO_BIT = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   r_data,
  input  logic          rx_empty,
  output logic          rd_uart,
  output logic [31:0]   w_data,
  output logic          wr_uart,
  input  logic          tx_full,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WDATA = 3'd1;
  localparam logic [2:0] S_BUS   = 3'd2;
  localparam logic [2:0] S_RSTAT = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] CODE_OK    = 8'h00;
  localparam logic [7:0] CODE_BADOP = 8'h01;
  localparam logic [7:0] CODE_TO    = 8'h02;
  localparam logic [7:0] STAT_TAG   = 8'hAC;

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TO_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        code_q, code_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [TO_BIT-1:0] cnt_q, cnt_d;
  logic [31:0]       wdata_d;
  logic              we_d;
  logic [31:0]       w_data_d;
  logic [7:0]        err_d;

  // Next-state, latched-field updates and the FIFO handshake strobes
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    code_d   = code_q;
    rdata_d  = rdata_q;
    cnt_d    = '0;
    wdata_d  = mem_wdata;
    we_d     = mem_we;
    err_d    = err_cnt;
    w_data_d = w_data;
    rd_uart  = 1'b0;
    wr_uart  = 1'b0;

    case (state_q)
      S_IDLE: begin
        rd_uart = ~rx_empty;
        if (!rx_empty) begin
          op_d   = r_data[31:24];
          addr_d = r_data[23:0];
          if (r_data[31:24] == OP_WRITE) begin
            state_d = S_WDATA;
          end else if (r_data[31:24] == OP_READ) begin
            we_d    = 1'b0;
            state_d = S_BUS;
          end else begin
            code_d  = CODE_BADOP;
            state_d = S_RSTAT;
          end
        end
      end
      S_WDATA: begin
        rd_uart = ~rx_empty;
        if (!rx_empty) begin
          wdata_d = r_data;
          we_d    = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + TO_BIT'(1);
        // ack takes priority over a timeout landing in the same cycle
        if (mem_ack) begin
          rdata_d = mem_rdata;
          code_d  = CODE_OK;
          state_d = S_RSTAT;
        end else if (cnt_q == TO_LAST) begin
          code_d  = CODE_TO;
          state_d = S_RSTAT;
        end
      end
      S_RSTAT: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          if (op_q == OP_READ && code_q == CODE_OK) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_IDLE;
          end
          if (code_q != CODE_OK && err_cnt != 8'hFF) begin
            err_d = err_cnt + 8'd1;
          end
        end
      end
      S_RDATA: begin
        wr_uart = ~tx_full;
        if (!tx_full) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // TX word is prepared one cycle ahead so it is a register while the push is pending
    if (state_d == S_RSTAT) begin
      w_data_d = {STAT_TAG, code_d, addr_d[15:0]};
    end else if (state_d == S_RDATA) begin
      w_data_d = rdata_d;
    end

    // strobes are combinational, so force them low during reset
    if (reset) begin
      rd_uart = 1'b0;
      wr_uart = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      code_q    <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      w_data    <= '0;
      busy      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      code_q    <= code_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      mem_req   <= (state_d == S_BUS);
      mem_we    <= we_d;
      mem_addr  <= addr_d[AW-1:0];
      mem_wdata <= wdata_d;
      w_data    <= w_data_d;
      busy      <= (state_d != S_IDLE);
      err_cnt   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
module tb_uart_cmd_bridge;

  localparam int unsigned AW     = 16;
  localparam int unsigned TO_CYC = 20;
  localparam int unsigned TO_BIT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   r_data;
  logic          rx_empty;
  logic          rd_uart;
  logic [31:0]   w_data;
  logic          wr_uart;
  logic          tx_full = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  // RX FIFO model (show-ahead) and TX capture
  logic [31:0] rx_mem [0:63];
  logic [31:0] tx_mem [0:63];
  int          pop_cyc [0:63];
  int          tx_cyc [0:63];
  int          rx_wr = 0;
  int          rx_rd = 0;
  int          tx_wr = 0;
  int          cyc = 0;

  // Bus responder state: ack_mode 0 = ack first cycle, 1 = never, 2 = ack in last timeout cycle
  int          ack_mode = 0;
  logic [31:0] rdata_val = '0;
  int          req_cyc = 0;
  int          last_req_len = 0;
  int          bus_n = 0;
  logic [15:0] bus_addr = '0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_wdata = '0;
  int          viol = 0;

  assign rx_empty = (rx_rd == rx_wr);
  assign r_data   = rx_mem[rx_rd];

  uart_cmd_bridge #(.AW(AW), .TO_CYC(TO_CYC), .TO_BIT(TO_BIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rd_uart   (rd_uart),
    .w_data    (w_data),
    .wr_uart   (wr_uart),
    .tx_full   (tx_full),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart) begin
      pop_cyc[rx_rd] <= cyc;
      rx_rd <= rx_rd + 1;
    end
    if (wr_uart) begin
      tx_mem[tx_wr] <= w_data;
      tx_cyc[tx_wr] <= cyc;
      tx_wr <= tx_wr + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_req) begin
      req_cyc = req_cyc + 1;
    end else begin
      if (req_cyc != 0) last_req_len = req_cyc;
      req_cyc = 0;
    end
    mem_ack   = mem_req && (ack_mode == 0 || (ack_mode == 2 && req_cyc == int'(TO_CYC)));
    mem_rdata = rdata_val;
    if (mem_ack) begin
      bus_n     = bus_n + 1;
      bus_addr  = mem_addr;
      bus_we    = mem_we;
      bus_wdata = mem_wdata;
    end
  end

  always @(negedge clk) begin
    #2;
    if ((rd_uart && rx_empty) || (wr_uart && tx_full) || (rd_uart && wr_uart)) viol = viol + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_rx(input logic [31:0] w);
    rx_mem[rx_wr] = w;
    rx_wr = rx_wr + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_wr >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    push_rx(32'h0200_0010);
    #1;
    checks++;
    if ({rd_uart, wr_uart, mem_req, busy, mem_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {rd_uart, wr_uart, mem_req, busy, mem_we});
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset_err_cnt: got %h required 00", err_cnt);
    end
    checks++;
    if (w_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_w_data: got %h required 00000000", w_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read;
    bit ok;
    rdata_val = 32'hDEAD_BEEF;
    wait_tx(2, ok);
    tick(3);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_timeout: got %0d tx words required 2", tx_wr);
    end
    checks++;
    if (tx_mem[0] !== 32'hAC00_0010) begin
      errors++;
      $display("FAIL read_status: got %h required AC000010", tx_mem[0]);
    end
    checks++;
    if (tx_mem[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_data: got %h required DEADBEEF", tx_mem[1]);
    end
    checks++;
    if (err_cnt !== 8'h00 || bus_we !== 1'b0 || bus_addr !== 16'h0010) begin
      errors++;
      $display("FAIL read_bus: got err=%h we=%b addr=%h required 00 0 0010", err_cnt, bus_we, bus_addr);
    end
    checks++;
    if (tx_cyc[0] - pop_cyc[0] !== 2 || tx_cyc[1] - pop_cyc[0] !== 3) begin
      errors++;
      $display("FAIL read_latency: got %0d,%0d required 2,3", tx_cyc[0] - pop_cyc[0], tx_cyc[1] - pop_cyc[0]);
    end
  endtask

  task automatic test_write;
    bit ok;
    int txb = tx_wr;
    int rxb = rx_wr;
    int nb  = bus_n;
    push_rx(32'h0100_1234);
    push_rx(32'h1234_5678);
    wait_tx(txb + 1, ok);
    tick(5);
    checks++;
    if (!ok || tx_wr !== txb + 1) begin
      errors++;
      $display("FAIL write_count: got %0d tx words required %0d", tx_wr, txb + 1);
    end
    checks++;
    if (tx_mem[txb] !== 32'hAC00_1234) begin
      errors++;
      $display("FAIL write_status: got %h required AC001234", tx_mem[txb]);
    end
    checks++;
    if (bus_n !== nb + 1 || bus_addr !== 16'h1234 || bus_we !== 1'b1 || bus_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_bus: got n=%0d addr=%h we=%b wdata=%h required n=%0d 1234 1 12345678",
               bus_n, bus_addr, bus_we, bus_wdata, nb + 1);
    end
    checks++;
    if (pop_cyc[rxb + 1] - pop_cyc[rxb] !== 1 || tx_cyc[txb] - pop_cyc[rxb] !== 3) begin
      errors++;
      $display("FAIL write_latency: got %0d,%0d required 1,3",
               pop_cyc[rxb + 1] - pop_cyc[rxb], tx_cyc[txb] - pop_cyc[rxb]);
    end
  endtask

  task automatic test_bad_op;
    bit ok;
    int txb = tx_wr;
    int rxb = rx_wr;
    int nb  = bus_n;
    rdata_val = 32'h0BAD_F00D;
    push_rx(32'h7F00_ABCD);
    push_rx(32'h0200_0020);
    wait_tx(txb + 3, ok);
    tick(3);
    checks++;
    if (!ok || tx_mem[txb] !== 32'hAC01_ABCD) begin
      errors++;
      $display("FAIL badop_status: got %h required AC01ABCD", tx_mem[txb]);
    end
    checks++;
    if (err_cnt !== 8'h01) begin
      errors++;
      $display("FAIL badop_err_cnt: got %h required 01", err_cnt);
    end
    checks++;
    if (tx_cyc[txb] - pop_cyc[rxb] !== 1) begin
      errors++;
      $display("FAIL badop_latency: got %0d required 1", tx_cyc[txb] - pop_cyc[rxb]);
    end
    checks++;
    if (bus_n !== nb + 1 || bus_addr !== 16'h0020) begin
      errors++;
      $display("FAIL badop_bus: got n=%0d addr=%h required n=%0d addr=0020", bus_n, bus_addr, nb + 1);
    end
    checks++;
    if (tx_mem[txb + 1] !== 32'hAC00_0020 || tx_mem[txb + 2] !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL badop_next: got %h %h required AC000020 0BADF00D", tx_mem[txb + 1], tx_mem[txb + 2]);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int txb = tx_wr;
    int rxb = rx_wr;
    int nb  = bus_n;
    ack_mode = 1;
    push_rx(32'h0200_0044);
    wait_tx(txb + 1, ok);
    tick(5);
    checks++;
    if (!ok || tx_wr !== txb + 1 || tx_mem[txb] !== 32'hAC02_0044) begin
      errors++;
      $display("FAIL timeout_status: got %h (%0d words) required AC020044 (%0d words)",
               tx_mem[txb], tx_wr, txb + 1);
    end
    checks++;
    if (last_req_len !== int'(TO_CYC) || bus_n !== nb) begin
      errors++;
      $display("FAIL timeout_req_len: got %0d acks=%0d required %0d acks=%0d",
               last_req_len, bus_n, TO_CYC, nb);
    end
    checks++;
    if (tx_cyc[txb] - pop_cyc[rxb] !== int'(TO_CYC) + 1 || err_cnt !== 8'h02) begin
      errors++;
      $display("FAIL timeout_latency: got %0d err=%h required %0d err=02",
               tx_cyc[txb] - pop_cyc[rxb], err_cnt, TO_CYC + 1);
    end
    // ack arriving in the final timeout cycle must still give an ok response
    txb = tx_wr;
    nb  = bus_n;
    ack_mode  = 2;
    rdata_val = 32'hCAFE_F00D;
    push_rx(32'h0200_0055);
    wait_tx(txb + 2, ok);
    tick(5);
    checks++;
    if (!ok || tx_mem[txb] !== 32'hAC00_0055 || tx_mem[txb + 1] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL ackwins_resp: got %h %h required AC000055 CAFEF00D", tx_mem[txb], tx_mem[txb + 1]);
    end
    checks++;
    if (last_req_len !== int'(TO_CYC) || bus_n !== nb + 1 || err_cnt !== 8'h02) begin
      errors++;
      $display("FAIL ackwins_bus: got len=%0d acks=%0d err=%h required %0d %0d 02",
               last_req_len, bus_n, err_cnt, TO_CYC, nb + 1);
    end
    ack_mode = 0;
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad;
    int txb = tx_wr;
    int rxb;
    int nb;
    tx_full = 1'b1;
    push_rx(32'h0100_0077);
    push_rx(32'hA5A5_A5A5);
    tick(6);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (wr_uart !== 1'b0 || w_data !== 32'hAC00_0077 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || tx_wr !== txb) begin
      errors++;
      $display("FAIL txfull_hold: got %0d bad cycles, %0d words required 0, %0d", bad, tx_wr, txb);
    end
    @(negedge clk);
    tx_full = 1'b0;
    wait_tx(txb + 1, ok);
    tick(5);
    checks++;
    if (!ok || tx_wr !== txb + 1 || tx_mem[txb] !== 32'hAC00_0077 || busy !== 1'b0) begin
      errors++;
      $display("FAIL txfull_release: got %h (%0d words) busy=%b required AC000077 (%0d words) busy=0",
               tx_mem[txb], tx_wr, busy, txb + 1);
    end
    // write header whose data word arrives 20 cycles later
    txb = tx_wr;
    rxb = rx_wr;
    nb  = bus_n;
    push_rx(32'h0100_0088);
    tick(3);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rd_uart !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || rx_rd !== rxb + 1) begin
      errors++;
      $display("FAIL wdata_gap: got %0d bad cycles, rd ptr %0d required 0, %0d", bad, rx_rd, rxb + 1);
    end
    push_rx(32'h1122_3344);
    wait_tx(txb + 1, ok);
    tick(3);
    checks++;
    if (!ok || tx_mem[txb] !== 32'hAC00_0088 || bus_n !== nb + 1 || bus_wdata !== 32'h1122_3344 ||
        bus_addr !== 16'h0088 || bus_we !== 1'b1) begin
      errors++;
      $display("FAIL wdata_late: got %h wdata=%h addr=%h we=%b required AC000088 11223344 0088 1",
               tx_mem[txb], bus_wdata, bus_addr, bus_we);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int bad;
    int txb = tx_wr;
    int rxb = rx_wr;
    logic [31:0] exp_w [0:4];
    exp_w[0] = 32'hAC00_0100;
    exp_w[1] = 32'h600D_CAFE;
    exp_w[2] = 32'hAC00_0200;
    exp_w[3] = 32'hAC00_0300;
    exp_w[4] = 32'h600D_CAFE;
    rdata_val = 32'h600D_CAFE;
    push_rx(32'h0200_0100);
    push_rx(32'h0100_0200);
    push_rx(32'h55AA_55AA);
    push_rx(32'h0200_0300);
    wait_tx(txb + 5, ok);
    tick(3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_mem[txb + i] !== exp_w[i]) bad++;
    end
    checks++;
    if (!ok || bad != 0 || tx_wr !== txb + 5) begin
      errors++;
      $display("FAIL b2b_order: got %0d wrong words, %0d words required 0, %0d", bad, tx_wr, txb + 5);
    end
    checks++;
    if (pop_cyc[rxb + 1] - pop_cyc[rxb] !== 4 || pop_cyc[rxb + 3] - pop_cyc[rxb + 1] !== 4) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d required 4,4",
               pop_cyc[rxb + 1] - pop_cyc[rxb], pop_cyc[rxb + 3] - pop_cyc[rxb + 1]);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen = 1'b0;
    int txb = tx_wr;
    ack_mode = 1;
    push_rx(32'h0200_0400);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_req: got mem_req=0 required 1 within 20 cycles");
    end
    tick(3);
    push_rx(32'h0200_0500);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, busy, rd_uart, wr_uart} !== 4'b0 || err_cnt !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_drop: got req/busy/rd/wr=%b err=%h required 0000 00",
               {mem_req, busy, rd_uart, wr_uart}, err_cnt);
    end
    tick(3);
    ack_mode  = 0;
    rdata_val = 32'h0ABC_DEF0;
    reset = 1'b0;
    wait_tx(txb + 2, ok);
    tick(5);
    checks++;
    if (!ok || tx_wr !== txb + 2 || tx_mem[txb] !== 32'hAC00_0500 || tx_mem[txb + 1] !== 32'h0ABC_DEF0) begin
      errors++;
      $display("FAIL rstmid_resume: got %h %h (%0d words) required AC000500 0ABCDEF0 (%0d words)",
               tx_mem[txb], tx_mem[txb + 1], tx_wr, txb + 2);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bad_op();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_rules: got %0d illegal strobe cycles required 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
